// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on both sides.
// One trial subtraction per cycle, MSB first; divide-by-zero short-circuits to DONE.
module seq_restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quot,
   output logic [WIDTH-1:0] out_rem,
   output logic             out_div0
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] quot_sr;
   logic [WIDTH-1:0] rem_sr;
   logic [WIDTH-1:0] divisor;
   logic             div0_flag;
   logic [WIDTH:0]   trial;

   // The stored remainder is always below the divisor, so its (WIDTH+1)th bit
   // is permanently zero and only the shifted-in trial word needs the extra bit.
   assign trial = {rem_sr, quot_sr[WIDTH-1]} + ~{1'b0, divisor} + {{WIDTH{1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = (in_b == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (counter == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
   end

   // Result registers are loaded on the first DONE cycle and then held until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter   <= '0;
         quot_sr   <= '0;
         rem_sr    <= '0;
         divisor   <= '0;
         div0_flag <= 1'b0;
         out_valid <= 1'b0;
         out_quot  <= '0;
         out_rem   <= '0;
         out_div0  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  divisor <= in_b;
                  if (in_b == '0) begin
                     quot_sr   <= '1;
                     rem_sr    <= in_a;
                     div0_flag <= 1'b1;
                  end else begin
                     quot_sr   <= in_a;
                     rem_sr    <= '0;
                     div0_flag <= 1'b0;
                     counter   <= CW'(WIDTH - 1);
                  end
               end
            end
            CALC: begin
               if (!trial[WIDTH]) begin
                  rem_sr  <= trial[WIDTH-1:0];
                  quot_sr <= {quot_sr[WIDTH-2:0], 1'b1};
               end else begin
                  rem_sr  <= {rem_sr[WIDTH-2:0], quot_sr[WIDTH-1]};
                  quot_sr <= {quot_sr[WIDTH-2:0], 1'b0};
               end
               counter <= counter - CW'(1);
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_quot  <= quot_sr;
                  out_rem   <= rem_sr;
                  out_div0  <= div0_flag;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, backpressure,
// mid-calculation reset and randomized traffic against an arithmetic reference.
module tb_seq_restoring_divider;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_quot;
   logic [W-1:0] out_rem;
   logic         out_div0;

   int tests_run;
   int tests_failed;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_quot  (out_quot),
      .out_rem   (out_rem),
      .out_div0  (out_div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result packed as {quotient, remainder, div0}.
   function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) begin
         return {{W{1'b1}}, a, 1'b1};
      end
      return {W'(a / b), W'(a % b), 1'b0};
   endfunction

   // Issues one operation from IDLE and waits (bounded) for out_valid.
   // lat counts rising edges after the accepting edge.
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W:0] res, output int lat);
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 'x;
      in_b     = 'x;
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = {out_quot, out_rem, out_div0};
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = 'x;
      in_b      = 'x;
      #3;
      tests_run++;
      if ({out_valid, out_quot, out_rem, out_div0, in_ready} !== {1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got v=%b q=%0d r=%0d d=%b rdy=%b, expected v=0 q=0 r=0 d=0 rdy=1",
                  out_valid, out_quot, out_rem, out_div0, in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_idle: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] da [6];
      logic [W-1:0] db [6];
      logic [2*W:0] res;
      logic [2*W:0] exp;
      int           lat;
      int           exp_lat;
      da = '{8'd200, 8'd255, 8'd0,  8'd5, 8'd255, 8'd100};
      db = '{8'd7,   8'd1,   8'd13, 8'd9, 8'd255, 8'd0};
      for (int i = 0; i < 6; i++) begin
         exp     = ref_div(da[i], db[i]);
         exp_lat = (db[i] == '0) ? 1 : W + 1;
         do_div(da[i], db[i], res, lat);
         tests_run++;
         if (lat !== exp_lat) begin
            tests_failed++;
            $display("[TB] FAIL latency %0d/%0d: got %0d edges, expected %0d", da[i], db[i], lat, exp_lat);
         end
         tests_run++;
         if (res[2*W:W+1] !== exp[2*W:W+1]) begin
            tests_failed++;
            $display("[TB] FAIL quot %0d/%0d: got %0d, expected %0d", da[i], db[i], res[2*W:W+1], exp[2*W:W+1]);
         end
         tests_run++;
         if (res[W:1] !== exp[W:1]) begin
            tests_failed++;
            $display("[TB] FAIL rem %0d/%0d: got %0d, expected %0d", da[i], db[i], res[W:1], exp[W:1]);
         end
         tests_run++;
         if (res[0] !== exp[0]) begin
            tests_failed++;
            $display("[TB] FAIL div0 %0d/%0d: got %b, expected %b", da[i], db[i], res[0], exp[0]);
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         tests_run++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL handshake_drop %0d/%0d: got v=%b rdy=%b, expected v=0 rdy=1",
                     da[i], db[i], out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [2*W:0] res;
      int           lat;
      do_div(8'd200, 8'd7, res, lat);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_a     = W'($urandom);
         in_b     = W'($urandom);
         @(posedge clk);
         #1;
         tests_run++;
         if ({out_valid, in_ready, out_quot, out_rem, out_div0} !== {1'b1, 1'b0, 8'd28, 8'd4, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_hold cycle %0d: got v=%b rdy=%b q=%0d r=%0d d=%b, expected v=1 rdy=0 q=28 r=4 d=0",
                     c, out_valid, in_ready, out_quot, out_rem, out_div0);
         end
      end
      in_valid  = 1'b0;
      in_a      = 'x;
      in_b      = 'x;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL backpressure_release: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [2*W:0] res;
      logic [2*W:0] exp;
      int           lat;
      bit           saw_valid;
      in_a     = 8'd150;
      in_b     = 8'd11;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 'x;
      in_b     = 'x;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({out_valid, out_quot, out_rem, out_div0, in_ready} !== {1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_calc: got v=%b q=%0d r=%0d d=%b rdy=%b, expected v=0 q=0 r=0 d=0 rdy=1",
                  out_valid, out_quot, out_rem, out_div0, in_ready);
      end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      saw_valid = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) saw_valid = 1'b1;
      end
      tests_run++;
      if (saw_valid) begin
         tests_failed++;
         $display("[TB] FAIL reset_discard: got an out_valid pulse, expected none");
      end
      exp = ref_div(8'd81, 8'd9);
      do_div(8'd81, 8'd9, res, lat);
      tests_run++;
      if (res !== exp || lat !== W + 1) begin
         tests_failed++;
         $display("[TB] FAIL after_reset 81/9: got q=%0d r=%0d d=%b lat=%0d, expected q=%0d r=%0d d=%b lat=%0d",
                  res[2*W:W+1], res[W:1], res[0], lat, exp[2*W:W+1], exp[W:1], exp[0], W + 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random(input int n);
      for (int i = 0; i < n; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         logic [2*W:0] exp;
         logic [2*W:0] got;
         bit           done;
         int           cyc;
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 15))
            0:       b = '0;
            1:       b = 8'd1;
            2:       a = '1;
            3:       b = a;
            default: ;
         endcase
         exp = ref_div(a, b);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         tests_run++;
         if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rand_ready op %0d: got %b, expected 1", i, in_ready);
         end
         in_a      = a;
         in_b      = b;
         in_valid  = 1'b1;
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         done = 1'b0;
         cyc  = 0;
         got  = '0;
         while (!done && cyc < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            if (out_valid === 1'b1 && out_ready) begin
               got  = {out_quot, out_rem, out_div0};
               done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
         end
         in_valid  = 1'b0;
         in_a      = 'x;
         in_b      = 'x;
         out_ready = 1'b0;
         tests_run++;
         if (!done || got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL rand_result %0d/%0d: got q=%0d r=%0d d=%b done=%b, expected q=%0d r=%0d d=%b",
                     a, b, got[2*W:W+1], got[W:1], got[0], done, exp[2*W:W+1], exp[W:1], exp[0]);
         end
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rand_drop %0d/%0d: got out_valid=%b, expected 0", a, b, out_valid);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_calc();
      test_random(2000);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
